add_sub: RTL and testbench

ADD_SUB -- requirements
Module: add_sub

---
 rtl/add_sub_pkg.sv | 27 ++
 rtl/add_sub_fa.sv | 16 +
 rtl/add_sub.sv | 116 +++++++++++
 tb/tb_add_sub.sv | 127 ++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the sign-magnitude adder/subtractor.
// Holds the default magnitude width, the sign-bit index helpers and
// the operand/result type definitions used at the default width.
package add_sub_pkg;

  // Default magnitude width of each operand.
  localparam int MAG_W_DEF = 2;

  // Operand: {sign, magnitude[MAG_W-1:0]}, so the sign sits at bit MAG_W.
  function automatic int op_sign_idx(input int mag_w);
    return mag_w;
  endfunction

  // Result: {sign, magnitude[MAG_W:0]}, so the sign sits at bit MAG_W+1.
  function automatic int res_sign_idx(input int mag_w);
    return mag_w + 1;
  endfunction

  // Sign-bit positions at the default width.
  localparam int OP_SIGN_IDX_DEF  = MAG_W_DEF;
  localparam int RES_SIGN_IDX_DEF = MAG_W_DEF + 1;

  // Sign-magnitude operand and result at the default width.
  typedef logic [MAG_W_DEF:0]   sm_operand_t;
  typedef logic [MAG_W_DEF+1:0] sm_result_t;

endpackage : add_sub_pkg

// File: rtl/add_sub_fa.sv
// One-bit full adder; one stage of the magnitude ripple chain.
module add_sub_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic c_o
);

  // Sum and carry-out of a single bit position.
  always_comb begin
    sum_o = a_i ^ b_i ^ c_i;
    c_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule : add_sub_fa

// File: rtl/add_sub.sv
// Registered sign-magnitude adder/subtractor (c = a + b or a - b).
// Magnitudes go through a ripple chain of add_sub_fa stages; the top
// carry picks which operand is larger when the magnitudes are subtracted.
// Optional feature: define ADD_SUB_COUT_EN to register the carry vector on
// cout; otherwise cout is tied to zero and has no register behind it.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  input  logic             s,
  output logic [MAG_W+1:0] c,
  output logic [MAG_W:0]   cout
);

  localparam int OP_SIGN  = op_sign_idx(MAG_W);
  localparam int RES_SIGN = res_sign_idx(MAG_W);

  logic             sign_a;
  logic             sign_b;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;
  logic             op;
  logic [MAG_W:0]   x_w;
  logic [MAG_W:0]   y_w;
  logic [MAG_W:0]   sum_w;
  logic [MAG_W+1:0] chain_w;
  logic [MAG_W:0]   carry_w;
  logic [MAG_W:0]   mag_res;
  logic             sign_res;
  logic [MAG_W+1:0] c_d;
  logic [MAG_W+1:0] c_q;

  assign sign_a = a[OP_SIGN];
  assign sign_b = b[OP_SIGN];
  assign mag_a  = a[MAG_W-1:0];
  assign mag_b  = b[MAG_W-1:0];

  // Differing signs turn the requested operation into its opposite.
  assign op  = sign_a ^ sign_b ^ s;
  assign x_w = {1'b0, mag_a};
  // Subtraction is X + ~Y + 1, with the +1 entering as the chain carry-in.
  assign y_w = op ? ~{1'b0, mag_b} : {1'b0, mag_b};

  assign chain_w[0] = op;

  generate
    for (genvar gi = 0; gi <= MAG_W; gi++) begin : g_stage
      add_sub_fa u_fa (
        .a_i   (x_w[gi]),
        .b_i   (y_w[gi]),
        .c_i   (chain_w[gi]),
        .sum_o (sum_w[gi]),
        .c_o   (chain_w[gi+1])
      );
    end
  endgenerate

  assign carry_w = chain_w[MAG_W+1:1];

  // Pick result sign/magnitude; a zero magnitude always yields all-zero c.
  always_comb begin
    mag_res  = sum_w;
    sign_res = sign_a;
    c_d      = '0;
    // No carry out of the top stage means |a| < |b|: the chain produced
    // |a|-|b| in two's complement, so negate it to get |b|-|a|.
    if (op && !carry_w[MAG_W]) begin
      mag_res  = ~sum_w + {{MAG_W{1'b0}}, 1'b1};
      sign_res = sign_b ^ s;
    end
    if (mag_res != '0) begin
      c_d[RES_SIGN]  = sign_res;
      c_d[MAG_W:0]   = mag_res;
    end
  end

  // Result register, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

`ifdef ADD_SUB_COUT_EN
  logic [MAG_W:0] cout_d;
  logic [MAG_W:0] cout_q;

  assign cout_d = carry_w;

  // Carry-vector register, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q <= '0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
`else
  // Only the top carry steers the result; the lower carries have no sink.
  logic unused_carry;
  assign unused_carry = ^carry_w[MAG_W-1:0];
  assign cout = '0;
`endif

endmodule : add_sub

// File: tb/tb_add_sub.sv
// Directed self-checking bench for add_sub at MAG_W = 2.
// Expected cout follows the ADD_SUB_COUT_EN build option (zero when off).
module tb_add_sub;
  import add_sub_pkg::*;

`ifdef ADD_SUB_COUT_EN
  localparam bit COUT_EN = 1'b1;
`else
  localparam bit COUT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  sm_operand_t a;
  sm_operand_t b;
  logic        s;
  sm_result_t  c;
  sm_operand_t cout;

  int errors = 0;
  int checks = 0;

  add_sub #(.MAG_W(MAG_W_DEF)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .s    (s),
    .c    (c),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_c(input string tag, input sm_result_t exp);
    checks++;
    assert (c === exp)
    else begin
      errors++;
      $error("FAIL %s c: got %b expected %b", tag, c, exp);
    end
  endtask

  task automatic check_cout(input string tag, input sm_operand_t exp_on);
    sm_operand_t exp;
    exp = COUT_EN ? exp_on : '0;
    checks++;
    assert (cout === exp)
    else begin
      errors++;
      $error("FAIL %s cout: got %b expected %b", tag, cout, exp);
    end
  endtask

  // Drive one operation at the falling edge, check 1 ns after the next rise.
  task automatic apply(input string tag, input sm_operand_t ai,
                       input sm_operand_t bi, input logic si,
                       input sm_result_t exp_c, input sm_operand_t exp_cout);
    @(negedge clk);
    a = ai;
    b = bi;
    s = si;
    @(posedge clk);
    #1;
    check_c(tag, exp_c);
    check_cout(tag, exp_cout);
    $display("txn %-10s a=%b b=%b s=%b -> c=%b cout=%b", tag, ai, bi, si, c, cout);
  endtask

  initial begin
    rst = 1'b1;
    a   = 3'b011;
    b   = 3'b001;
    s   = 1'b0;
    #1;
    check_c("reset", 4'b0000);
    check_cout("reset", 3'b000);
    @(posedge clk);
    #1;
    check_c("reset_edge", 4'b0000);
    check_cout("reset_edge", 3'b000);
    @(negedge clk);
    rst = 1'b0;

    apply("p1_p2",    3'b001, 3'b010, 1'b0, 4'b0011, 3'b000);
    apply("m3_m3",    3'b111, 3'b111, 1'b0, 4'b1110, 3'b011);
    apply("p1_sub_p3",3'b001, 3'b011, 1'b1, 4'b1010, 3'b001);
    apply("m2_p2",    3'b110, 3'b010, 1'b0, 4'b0000, 3'b111);
    apply("negzero",  3'b100, 3'b000, 1'b0, 4'b0000, 3'b111);
    apply("p3_sub_m1",3'b011, 3'b101, 1'b1, 4'b0100, 3'b011);
    apply("p3_sub_p1",3'b011, 3'b001, 1'b1, 4'b0010, 3'b111);
    apply("p3_sub_p3",3'b011, 3'b011, 1'b1, 4'b0000, 3'b111);
    apply("p3_p3",    3'b011, 3'b011, 1'b0, 4'b0110, 3'b011);
    apply("m1_sub_p3",3'b101, 3'b011, 1'b1, 4'b1100, 3'b011);
    apply("p1_m3",    3'b001, 3'b111, 1'b0, 4'b1010, 3'b001);
    apply("m3_p1",    3'b111, 3'b001, 1'b0, 4'b1010, 3'b111);
    apply("m0_sub_m2",3'b100, 3'b110, 1'b1, 4'b0010, 3'b001);

    // Hold a non-zero result, then assert rst between edges.
    apply("pre_rst",  3'b111, 3'b111, 1'b0, 4'b1110, 3'b011);
    #1;
    rst = 1'b1;
    #1;
    check_c("async_rst", 4'b0000);
    check_cout("async_rst", 3'b000);
    $display("txn %-10s rst=1 mid-cycle -> c=%b cout=%b", "async_rst", c, cout);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_c("post_rst", 4'b1110);
    check_cout("post_rst", 3'b011);
    $display("txn %-10s a=%b b=%b s=%b -> c=%b cout=%b", "post_rst", a, b, s, c, cout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule : tb_add_sub
